// File: rtl/spi_host_master.sv
// Mode-0, MSB-first SPI byte master for the control CPU. It drives the guest core's
// SCK/DI pins and its four active-low selects, and samples DO through a 2-flop synchroniser.
module spi_host_master #(
  parameter int unsigned DIV_MIN = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] div,
  input  logic [1:0] cs_sel,
  input  logic       cs_active,
  input  logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_conf_n,
  output logic       spi_ss2_n,
  output logic       spi_ss3_n,
  output logic       spi_ss4_n
);

  localparam logic [7:0] DIV_FLOOR = 8'(DIV_MIN);

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  state_t     state_q, state_d;
  logic [7:0] half_q, half_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       busy_q, busy_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;
  logic [3:0] sel_n_q, sel_n_d;
  logic       miso_s1_q, miso_s2_q;
  logic [7:0] div_eff;

  assign div_eff = (div < DIV_FLOOR) ? DIV_FLOOR : div;

  // A phase ends when cnt reaches half, so each SCK level lasts half+1 clocks.
  always_comb begin
    state_d    = state_q;
    half_d     = half_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    busy_d     = busy_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    sel_n_d    = sel_n_q;

    // Selects only move while idle, keeping SCK edges clear of select edges.
    if (!busy_q) begin
      sel_n_d = 4'hF;
      if (cs_active) sel_n_d[cs_sel] = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (tx_req) begin
          shift_d = tx_data;
          half_d  = div_eff;
          bit_d   = 3'd7;
          cnt_d   = 8'd0;
          mosi_d  = tx_data[7];
          sck_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = LO;
        end
      end
      LO: begin
        if (cnt_q == half_q) begin
          cnt_d   = 8'd0;
          sck_d   = 1'b1;
          state_d = HI;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HI: begin
        if (cnt_q == half_q) begin
          cnt_d      = 8'd0;
          sck_d      = 1'b0;
          rx_shift_d = {rx_shift_q[6:0], miso_s2_q};
          if (bit_q != 3'd0) begin
            bit_d   = bit_q - 3'd1;
            shift_d = {shift_q[6:0], 1'b0};
            mosi_d  = shift_q[6];
            state_d = LO;
          end else begin
            rx_data_d  = {rx_shift_q[6:0], miso_s2_q};
            rx_valid_d = 1'b1;
            busy_d     = 1'b0;
            state_d    = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      half_q     <= 8'd0;
      cnt_q      <= 8'd0;
      bit_q      <= 3'd0;
      shift_q    <= 8'd0;
      rx_shift_q <= 8'd0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      sel_n_q    <= 4'hF;
      miso_s1_q  <= 1'b0;
      miso_s2_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_q     <= half_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      sel_n_q    <= sel_n_d;
      miso_s1_q  <= spi_miso;
      miso_s2_q  <= miso_s1_q;
    end
  end

  assign busy       = busy_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign spi_sck    = sck_q;
  assign spi_mosi   = mosi_q;
  assign spi_conf_n = sel_n_q[0];
  assign spi_ss2_n  = sel_n_q[1];
  assign spi_ss3_n  = sel_n_q[2];
  assign spi_ss4_n  = sel_n_q[3];

endmodule

// File: tb/tb_spi_host_master.sv
// Self-checking bench for spi_host_master: a table of byte transfers plus hand-written
// sequences for request-while-busy, select timing, reset mid-transfer and back-to-back bytes.
module tb_spi_host_master;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] div = 8'd0;
  logic [1:0] cs_sel = 2'd0;
  logic       cs_active = 1'b0;
  logic       tx_req = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       busy;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_conf_n, spi_ss2_n, spi_ss3_n, spi_ss4_n;
  logic [3:0] sel_n;

  spi_host_master #(.DIV_MIN(2)) dut (
    .clk(clk), .reset(reset), .div(div), .cs_sel(cs_sel), .cs_active(cs_active),
    .tx_req(tx_req), .tx_data(tx_data), .busy(busy), .rx_data(rx_data),
    .rx_valid(rx_valid), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_conf_n(spi_conf_n), .spi_ss2_n(spi_ss2_n), .spi_ss3_n(spi_ss3_n),
    .spi_ss4_n(spi_ss4_n)
  );

  always #5 clk = ~clk;

  assign sel_n = {spi_ss4_n, spi_ss3_n, spi_ss2_n, spi_conf_n};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Mode-0 slave model: presents the MSB up front and advances on every SCK fall.
  int         falls = 0;
  int         base = 0;
  int         rel;
  logic [7:0] miso_byte = 8'd0;
  always @(negedge spi_sck) falls <= falls + 1;
  assign rel = falls - base;
  assign spi_miso = (rel >= 0 && rel < 8) ? miso_byte[3'(7 - rel)] : 1'b0;

  int checks = 0;
  int errors = 0;

  int         r_busy, r_rises, r_hi_min, r_hi_max, r_lo_min, r_lo_max;
  int         r_rxv, r_sel_bad, r_timeout, r_first_cyc, r_last_cyc;
  logic       r_first_busy, r_first_mosi, r_post_busy;
  logic [7:0] r_mosi, r_rx;
  logic [3:0] r_exit_sel, r_post_sel;

  typedef struct {
    logic [7:0] div;
    logic [1:0] sel;
    logic [7:0] tx;
    logic [7:0] miso;
    int         h;
    int         busy_len;
    logic [7:0] rx;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [3:0] expSel(input logic [1:0] s, input logic a);
    logic [3:0] r;
    r = 4'hF;
    if (a) r[s] = 1'b0;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Sets up divisor/select, waits one cycle for the select to land, then pulses tx_req.
  // Returns at the negedge of the first cycle in which busy should be high.
  task automatic applyStimulus(input logic [7:0] d, input logic [1:0] sel,
                               input logic [7:0] tx, input logic [7:0] mb);
    @(negedge clk);
    div = d;
    cs_sel = sel;
    cs_active = 1'b1;
    @(negedge clk);
    miso_byte = mb;
    base = falls;
    tx_data = tx;
    tx_req = 1'b1;
    @(negedge clk);
    tx_req = 1'b0;
  endtask

  task automatic recordRun(input logic level, input int run);
    if (level) begin
      if (run < r_hi_min) r_hi_min = run;
      if (run > r_hi_max) r_hi_max = run;
    end else begin
      if (run < r_lo_min) r_lo_min = run;
      if (run > r_lo_max) r_lo_max = run;
    end
  endtask

  // Samples one transfer at negedges until busy drops (bounded), optionally injecting
  // a tx_req, a reset or a select change at a given busy cycle, or chaining a new byte.
  task automatic observeTransfer(input logic [1:0] sel, input int inj_req, input int inj_rst,
                                 input int inj_cs, input logic [1:0] new_sel, input bit chain,
                                 input logic [7:0] chain_tx, input logic [7:0] chain_miso);
    logic prev_sck;
    int   run;
    bit   done;
    prev_sck = 1'b0; run = 0; done = 1'b0;
    r_busy = 0; r_rises = 0; r_rxv = 0; r_sel_bad = 0; r_timeout = 1;
    r_hi_min = 1000; r_hi_max = 0; r_lo_min = 1000; r_lo_max = 0;
    r_mosi = 8'd0; r_rx = 8'd0; r_post_busy = 1'bx; r_post_sel = 4'hx;
    r_first_cyc = 0; r_last_cyc = 0;
    for (int n = 1; n <= 400; n++) begin
      if (n == 1) begin
        r_first_busy = busy;
        r_first_mosi = spi_mosi;
      end
      if (rx_valid === 1'b1) r_rxv++;
      if (busy === 1'b1) begin
        if (r_busy == 0) r_first_cyc = cyc;
        r_last_cyc = cyc;
        r_busy++;
        if (sel_n !== expSel(sel, 1'b1)) r_sel_bad++;
        if (spi_sck === 1'b1 && prev_sck === 1'b0) begin
          r_rises++;
          r_mosi = {r_mosi[6:0], spi_mosi};
        end
        if (spi_sck !== prev_sck) begin
          if (run > 0) recordRun(prev_sck, run);
          run = 1;
        end else begin
          run++;
        end
        prev_sck = spi_sck;
      end else begin
        if (run > 0) recordRun(prev_sck, run);
        r_rx = rx_data;
        r_exit_sel = sel_n;
        r_timeout = 0;
        done = 1'b1;
      end
      if (done) break;
      if (n == inj_req) begin
        tx_req = 1'b1;
        tx_data = 8'h55;
      end else begin
        tx_req = 1'b0;
      end
      if (n == inj_rst) reset = 1'b1;
      if (n == inj_cs) cs_sel = new_sel;
      @(negedge clk);
    end
    tx_req = 1'b0;
    if (done && chain) begin
      miso_byte = chain_miso;
      base = falls;
      tx_data = chain_tx;
      tx_req = 1'b1;
      @(negedge clk);
      tx_req = 1'b0;
    end else if (done && inj_rst < 0) begin
      @(negedge clk);
      if (rx_valid === 1'b1) r_rxv++;
      r_post_busy = busy;
      r_post_sel = sel_n;
    end
  endtask

  initial begin
    int first_a;

    vecs[0] = '{8'd2, 2'd1, 8'hA5, 8'h3C, 3, 48, 8'h3C};
    vecs[1] = '{8'd0, 2'd0, 8'h5A, 8'hC3, 3, 48, 8'hC3};
    vecs[2] = '{8'd1, 2'd2, 8'h00, 8'hFF, 3, 48, 8'hFF};
    vecs[3] = '{8'd9, 2'd3, 8'hFF, 8'h00, 10, 160, 8'h00};
    vecs[4] = '{8'd3, 2'd1, 8'h81, 8'h7E, 4, 64, 8'h7E};

    repeat (3) @(negedge clk);
    checkOutput("rst_sck", spi_sck, 1'b0);
    checkOutput("rst_mosi", spi_mosi, 1'b0);
    checkOutput("rst_sel", sel_n, 4'hF);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_rxv", rx_valid, 1'b0);
    checkOutput("rst_rx", rx_data, 8'h00);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].div, vecs[i].sel, vecs[i].tx, vecs[i].miso);
      observeTransfer(vecs[i].sel, -1, -1, -1, 2'd0, 1'b0, 8'd0, 8'd0);
      checkOutput($sformatf("v%0d_timeout", i), r_timeout, 0);
      checkOutput($sformatf("v%0d_first_busy", i), r_first_busy, 1'b1);
      checkOutput($sformatf("v%0d_first_mosi", i), r_first_mosi, vecs[i].tx[7]);
      checkOutput($sformatf("v%0d_busy_len", i), r_busy, vecs[i].busy_len);
      checkOutput($sformatf("v%0d_mosi_bits", i), r_mosi, vecs[i].tx);
      checkOutput($sformatf("v%0d_sck_rises", i), r_rises, 8);
      checkOutput($sformatf("v%0d_hi_min", i), r_hi_min, vecs[i].h);
      checkOutput($sformatf("v%0d_hi_max", i), r_hi_max, vecs[i].h);
      checkOutput($sformatf("v%0d_lo_min", i), r_lo_min, vecs[i].h);
      checkOutput($sformatf("v%0d_lo_max", i), r_lo_max, vecs[i].h);
      checkOutput($sformatf("v%0d_rxv_cnt", i), r_rxv, 1);
      checkOutput($sformatf("v%0d_rx_data", i), r_rx, vecs[i].rx);
      checkOutput($sformatf("v%0d_sel_bad", i), r_sel_bad, 0);
      checkOutput($sformatf("v%0d_post_busy", i), r_post_busy, 1'b0);
    end

    $display("[TB] request during busy");
    applyStimulus(8'd2, 2'd1, 8'hFF, 8'h5A);
    observeTransfer(2'd1, 10, -1, -1, 2'd0, 1'b0, 8'd0, 8'd0);
    checkOutput("rq_busy_len", r_busy, 48);
    checkOutput("rq_mosi_bits", r_mosi, 8'hFF);
    checkOutput("rq_rxv_cnt", r_rxv, 1);
    checkOutput("rq_rx_data", r_rx, 8'h5A);
    checkOutput("rq_post_busy", r_post_busy, 1'b0);

    $display("[TB] select timing");
    applyStimulus(8'd2, 2'd1, 8'h96, 8'h69);
    observeTransfer(2'd1, -1, -1, 20, 2'd3, 1'b0, 8'd0, 8'd0);
    checkOutput("cs_sel_bad", r_sel_bad, 0);
    checkOutput("cs_exit_sel", r_exit_sel, 4'hD);
    checkOutput("cs_post_sel", r_post_sel, 4'h7);
    checkOutput("cs_rx_data", r_rx, 8'h69);
    cs_active = 1'b0;
    @(negedge clk);
    checkOutput("cs_idle_off", sel_n, 4'hF);

    $display("[TB] reset mid-transfer");
    applyStimulus(8'd2, 2'd1, 8'h81, 8'h81);
    observeTransfer(2'd1, -1, 25, -1, 2'd0, 1'b0, 8'd0, 8'd0);
    checkOutput("rs_timeout", r_timeout, 0);
    checkOutput("rs_busy_len", r_busy, 25);
    checkOutput("rs_rxv_cnt", r_rxv, 0);
    checkOutput("rs_sck", spi_sck, 1'b0);
    checkOutput("rs_busy", busy, 1'b0);
    checkOutput("rs_sel", sel_n, 4'hF);
    checkOutput("rs_rx_data", rx_data, 8'h00);
    checkOutput("rs_rxv", rx_valid, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(8'd2, 2'd1, 8'h81, 8'h81);
    observeTransfer(2'd1, -1, -1, -1, 2'd0, 1'b0, 8'd0, 8'd0);
    checkOutput("rs2_busy_len", r_busy, 48);
    checkOutput("rs2_mosi_bits", r_mosi, 8'h81);
    checkOutput("rs2_rxv_cnt", r_rxv, 1);
    checkOutput("rs2_rx_data", r_rx, 8'h81);

    $display("[TB] back-to-back");
    applyStimulus(8'd2, 2'd0, 8'hC5, 8'h3A);
    observeTransfer(2'd0, -1, -1, -1, 2'd0, 1'b1, 8'h5C, 8'hA3);
    first_a = r_first_cyc;
    checkOutput("bb_a_busy_len", r_busy, 48);
    checkOutput("bb_a_rx_data", r_rx, 8'h3A);
    observeTransfer(2'd0, -1, -1, -1, 2'd0, 1'b0, 8'd0, 8'd0);
    checkOutput("bb_b_first_busy", r_first_busy, 1'b1);
    checkOutput("bb_b_busy_len", r_busy, 48);
    checkOutput("bb_b_mosi_bits", r_mosi, 8'h5C);
    checkOutput("bb_b_rx_data", r_rx, 8'hA3);
    checkOutput("bb_total_span", r_last_cyc - first_a + 1, 97);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_host_master.md
# spi_host_master

SPI master used by the DeMiSTify control CPU to talk to the guest core's MiST-style SPI slave (SPI_SCK / SPI_DI / SPI_DO / SPI_SS2 / SPI_SS3 / SPI_SS4 / CONF_DATA0). It generates mode 0, MSB-first byte transfers and drives the four active-low selects. It sits between the control CPU's register interface and the board top, where its outputs connect straight to the guest's SPI pins.

## Interface
- DIV_MIN, 2: floor applied to the runtime divisor. The effective divisor is max(div, DIV_MIN).
- clk  in  1  system clock; everything is synchronous to it.
- reset  in  1  synchronous, active-high reset.
- div  in  8  SCK half-period control. Half-period H = max(div, DIV_MIN) + 1 clk cycles. Sampled only at transfer start.
- cs_sel  in  2  select target: 0 = CONF_DATA0, 1 = SS2, 2 = SS3, 3 = SS4.
- cs_active  in  1  level input; while high, the selected line is asserted low.
- tx_req  in  1  single-cycle request to transfer tx_data.
- tx_data  in  8  byte to send. Captured in the cycle tx_req is accepted.
- busy  out  1  high while a transfer is in progress.
- rx_data  out  8  last received byte. Held until the next completion.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- spi_sck  out  1  to guest SPI_SCK.
- spi_mosi  out  1  to guest SPI_DI.
- spi_miso  in  1  from guest SPI_DO. Asynchronous; synchronised internally.
- spi_conf_n, spi_ss2_n, spi_ss3_n, spi_ss4_n  out  1 each  active-low selects.

## Operation
- **Reset values:** spi_sck=0, spi_mosi=0, all selects=1, busy=0, rx_valid=0, rx_data=0x00, state=IDLE, synchroniser flops=0.
- **Selects:**
  - Registered as (cs_active && cs_sel==n) ? 0 : 1.
  - Updated only in cycles where busy=0. Changes to cs_sel/cs_active during a transfer take effect on the first cycle after busy falls.
  - Transfers are allowed with no select asserted.
- **States:** IDLE, LO, HI.
  - **IDLE:** when tx_req=1:
    - load shift register from tx_data;
    - latch H;
    - bit counter = 7;
    - spi_mosi = tx_data[7];
    - go to LO; busy=1 from the next cycle.
  - **LO:** spi_sck=0 for H cycles, then go to HI with spi_sck=1.
  - **HI:** spi_sck=1 for H cycles.
    - On the last HI cycle, shift the synchronised MISO into rx_shift[0].
    - If bit counter != 0: decrement, go to LO, drive the next MOSI bit.
    - If bit counter = 0: go to IDLE, set rx_data = rx_shift, pulse rx_valid, busy=0, spi_sck=0.
- **MISO path:** 2-flop synchroniser. Sampling on the last HI cycle gives at least H-1 ≥ 2 cycles of settle after the rising edge.
- **MOSI changes** only on the LO entry edge, so it is stable H cycles before each SCK rise (mode 0).
- **tx_req while busy=1:** ignored. No queueing, no effect on the current transfer.
- **tx_req in the same cycle busy falls:** ignored (busy is still 1 in that cycle). A new request is accepted from the following cycle.
- **Reset mid-transfer:** all outputs return to reset values at the next edge, no rx_valid is issued, and rx_data is cleared to 0x00.

## Timing
- Transfer length: 16·H clk cycles of busy=1. Example: div=2 gives H=3 and 48 cycles.
- Acceptance latency: busy and the first spi_mosi bit are valid 1 cycle after the tx_req edge.
- rx_valid coincides with the cycle busy drops to 0 and spi_sck returns to 0.
- Minimum gap between consecutive transfers: 1 idle cycle, i.e. 16·H+1 cycles per byte.
- Select setup and hold: select edges occur only while idle, so there is at least one clk cycle between a select edge and the first or last SCK edge.

## Test plan
- **Basic byte, div=2:** select SS2, send tx_data=0xA5 while the MISO model returns 0x3C.
  - spi_mosi shows 1,0,1,0,0,1,0,1 on successive SCK rises.
  - 8 SCK pulses of 3-high / 3-low.
  - busy high for exactly 48 cycles.
  - rx_valid one cycle, rx_data=0x3C.
  - spi_ss2_n=0 throughout; the other three selects stay 1.
- **Divisor clamp:** div=0 and div=1 both give H=3 (48-cycle transfer). div=9 gives H=10 (160 cycles).
- **Request during busy:** a second tx_req=0x55 at cycle 10 of a 0xFF transfer produces no change. Exactly one rx_valid; MOSI bits all 1.
- **Select timing:** toggle cs_sel 1→3 at cycle 20 of a transfer.
  - spi_ss2_n stays 0 until busy falls.
  - spi_ss4_n goes 0 on the first cycle after busy falls.
  - cs_active=0 during an idle period deasserts all selects on the next cycle.
- **Reset mid-transfer:** assert reset at cycle 25 of a 0x81 transfer.
  - Next cycle: spi_sck=0, busy=0, selects=1, rx_data=0x00, no rx_valid.
  - A following 0x81 transfer completes normally.
- **Back-to-back:** issue tx_req on the first cycle after rx_valid. It is accepted, and two bytes complete in 2×48+1 cycles with correct rx_data each.
